// File: rtl/mac_dec_rr_if.sv
// Bus bundle for mac_dec_rr: per-port ingress FIFOs, header FIFO, body FIFO and drop strobe.
// The master side is the decoder; the slave side is the FIFO environment.
interface mac_dec_rr_if #(
    parameter int NPORT     = 4,
    parameter int HDR_BYTES = 14,
    parameter int LEN_W     = 11
);
    localparam int PID_W = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int HW    = HDR_BYTES * 8 + LEN_W + PID_W;

    // Ingress PHY FIFOs (first-word-fall-through)
    logic [NPORT*8-1:0] i_fifo_dout;
    logic [NPORT-1:0]   i_fifo_empty;
    logic [NPORT-1:0]   i_fifo_aempty;
    logic [NPORT-1:0]   i_fifo_del;
    logic [NPORT-1:0]   i_fifo_rden;

    // Header FIFO
    logic [HW-1:0]      h_fifo_din;
    logic               h_fifo_wren;
    logic               h_fifo_full;

    // Body FIFO
    logic [7:0]         b_fifo_din;
    logic               b_fifo_wren;
    logic               b_fifo_del;
    logic               b_fifo_afull;

    logic               drop_pulse;

    modport master (
        input  i_fifo_dout, i_fifo_empty, i_fifo_aempty, i_fifo_del, h_fifo_full, b_fifo_afull,
        output i_fifo_rden, h_fifo_din, h_fifo_wren, b_fifo_din, b_fifo_wren, b_fifo_del,
               drop_pulse
    );

    modport slave (
        output i_fifo_dout, i_fifo_empty, i_fifo_aempty, i_fifo_del, h_fifo_full, b_fifo_afull,
        input  i_fifo_rden, h_fifo_din, h_fifo_wren, b_fifo_din, b_fifo_wren, b_fifo_del,
               drop_pulse
    );
endinterface

// File: rtl/mac_dec_rr.sv
// mac_dec_rr: round-robin frame decoder. Grants one eligible ingress port at a time, splits the
// frame into a fixed-size header (written with length and port id to the header FIFO) and a
// payload byte stream (written to the body FIFO). Runts and oversize frames are dropped.
module mac_dec_rr #(
    parameter int NPORT     = 4,
    parameter int HDR_BYTES = 14,
    parameter int LEN_W     = 11
) (
    input  logic         clk,
    input  logic         arst_n,
    mac_dec_rr_if.master bus
);
    localparam int PID_W = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int HW    = HDR_BYTES * 8 + LEN_W + PID_W;
    localparam int HDR_W = HDR_BYTES * 8;
    localparam int CNT_W = $clog2(HDR_BYTES + 1);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StHeader  = 3'd1,
        StPayload = 3'd2,
        StDiscard = 3'd3,
        StEnd     = 3'd4
    } state_e;

    state_e           state_q;
    logic [PID_W-1:0] pid_q;
    logic [PID_W-1:0] last_pid_q;
    logic [CNT_W-1:0] cnt_q;
    logic [HDR_W-1:0] hdr_q;
    logic [LEN_W-1:0] len_q;

    logic [HW-1:0]    h_din_q;
    logic             h_wren_q;
    logic [7:0]       b_din_q;
    logic             b_wren_q;
    logic             b_del_q;
    logic             drop_q;

    logic             active;
    logic             pop;
    logic             pop_del;
    logic [7:0]       pop_byte;
    logic [LEN_W-1:0] len_inc;
    logic             len_sat;
    logic             grant_vld;
    logic [PID_W-1:0] grant_pid;
    logic [NPORT-1:0] rden;

    // Current-port view of the ingress FIFOs and the saturating length increment
    always_comb begin
        active   = (state_q == StHeader) || (state_q == StPayload) || (state_q == StDiscard);
        pop      = active && !bus.i_fifo_empty[pid_q];
        pop_byte = bus.i_fifo_dout[{pid_q, 3'b000} +: 8];
        pop_del  = bus.i_fifo_del[pid_q];
        len_inc  = (&len_q) ? len_q : len_q + LEN_W'(1);
        len_sat  = &len_inc;
    end

    // Pop strobe: only the granted port, only while it has data; zero in reset via state
    always_comb begin
        rden = '0;
        if (pop) begin
            rden[pid_q] = 1'b1;
        end
    end

    // Round-robin search starting one past the last granted port
    always_comb begin
        grant_vld = 1'b0;
        grant_pid = '0;
        for (int i = 1; i <= NPORT; i++) begin
            if (!grant_vld && !bus.i_fifo_aempty[(int'(last_pid_q) + i) % NPORT]) begin
                grant_vld = 1'b1;
                grant_pid = PID_W'((int'(last_pid_q) + i) % NPORT);
            end
        end
    end

    // Frame FSM with registered write strobes; strobes default low so each is one cycle wide
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= StIdle;
            pid_q      <= '0;
            last_pid_q <= PID_W'(NPORT - 1);
            cnt_q      <= '0;
            hdr_q      <= '0;
            len_q      <= '0;
            h_din_q    <= '0;
            h_wren_q   <= 1'b0;
            b_din_q    <= '0;
            b_wren_q   <= 1'b0;
            b_del_q    <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            h_wren_q <= 1'b0;
            b_wren_q <= 1'b0;
            b_del_q  <= 1'b0;
            drop_q   <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (!bus.h_fifo_full && !bus.b_fifo_afull && grant_vld) begin
                        pid_q      <= grant_pid;
                        last_pid_q <= grant_pid;
                        state_q    <= StHeader;
                    end
                end
                StHeader: begin
                    if (pop) begin
                        hdr_q <= HDR_W'({hdr_q, pop_byte});
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (pop_del) begin
                            // Delimiter inside the header: runt, nothing was written yet
                            drop_q  <= 1'b1;
                            state_q <= StEnd;
                        end else if (cnt_q == CNT_W'(HDR_BYTES - 1)) begin
                            state_q <= StPayload;
                        end
                    end
                end
                StPayload: begin
                    if (pop) begin
                        b_din_q  <= pop_byte;
                        b_wren_q <= 1'b1;
                        len_q    <= len_inc;
                        if (pop_del) begin
                            b_del_q  <= 1'b1;
                            h_wren_q <= 1'b1;
                            h_din_q  <= {hdr_q, len_inc, pid_q};
                            state_q  <= StEnd;
                        end else if (len_sat) begin
                            state_q <= StDiscard;
                        end
                    end
                end
                StDiscard: begin
                    // Delimiter without write tells the body FIFO to roll back the partial frame
                    if (pop && pop_del) begin
                        b_del_q <= 1'b1;
                        drop_q  <= 1'b1;
                        state_q <= StEnd;
                    end
                end
                StEnd: begin
                    cnt_q   <= '0;
                    hdr_q   <= '0;
                    len_q   <= '0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StEnd;
                end
            endcase
        end
    end

    assign bus.i_fifo_rden = rden;
    assign bus.h_fifo_din  = h_din_q;
    assign bus.h_fifo_wren = h_wren_q;
    assign bus.b_fifo_din  = b_din_q;
    assign bus.b_fifo_wren = b_wren_q;
    assign bus.b_fifo_del  = b_del_q;
    assign bus.drop_pulse  = drop_q;

endmodule

// File: tb/tb_mac_dec_rr.sv
// Scoreboard bench for mac_dec_rr (NPORT=4, HDR_BYTES=14, LEN_W=6 so oversize frames are short).
// Ingress FIFOs are modelled as queues; each pushed frame appends its expected output events.
module tb_mac_dec_rr;
    localparam int NPORT     = 4;
    localparam int HDR_BYTES = 14;
    localparam int LEN_W     = 6;
    localparam int PID_W     = 2;
    localparam int LEN_MAX   = (1 << LEN_W) - 1;

    // kind: 0 body write {del,byte}, 1 header write, 2 drop {drop_pulse,b_fifo_del}
    typedef struct packed {
        logic [1:0]   kind;
        logic [127:0] data;
    } ev_t;

    logic             clk    = 1'b0;
    logic             arst_n = 1'b0;
    int               n_checks = 0;
    int               n_pass   = 0;
    int               pops     = 0;
    int               ev_cnt   = 0;
    ev_t              exp_q[$];
    logic [8:0]       src_q[NPORT][$];
    logic [NPORT-1:0] stall      = '0;
    logic [NPORT-1:0] pend_rden  = '0;
    logic [NPORT-1:0] pend_empty = '0;

    always #5 clk = ~clk;

    mac_dec_rr_if #(.NPORT(NPORT), .HDR_BYTES(HDR_BYTES), .LEN_W(LEN_W)) bus ();

    mac_dec_rr #(.NPORT(NPORT), .HDR_BYTES(HDR_BYTES), .LEN_W(LEN_W)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    function automatic logic src_busy();
        logic b;
        b = 1'b0;
        for (int p = 0; p < NPORT; p++) if (src_q[p].size() != 0) b = 1'b1;
        return b;
    endfunction

    // Drive FIFO outputs from the queue heads; a port is eligible once a whole frame is queued
    task automatic update_inputs();
        logic [NPORT*8-1:0] dout;
        logic [NPORT-1:0]   empty;
        logic [NPORT-1:0]   aempty;
        logic [NPORT-1:0]   del;
        dout = '0; empty = '1; aempty = '1; del = '0;
        for (int p = 0; p < NPORT; p++) begin
            if (src_q[p].size() > 0) begin
                dout[p*8 +: 8] = src_q[p][0][7:0];
                del[p]         = src_q[p][0][8];
                empty[p]       = stall[p];
            end
            for (int k = 0; k < src_q[p].size(); k++) if (src_q[p][k][8]) aempty[p] = 1'b0;
        end
        bus.i_fifo_dout   = dout;
        bus.i_fifo_empty  = empty;
        bus.i_fifo_aempty = aempty;
        bus.i_fifo_del    = del;
    endtask

    // Queue a frame on port p and append its expected events (runt_at>0: delimiter on that header byte)
    task automatic push_frame(input int p, input int seed, input int plen, input int runt_at);
        logic [HDR_BYTES*8-1:0] hdr;
        logic [7:0]             b;
        logic                   last;
        ev_t                    e;
        int                     nh;
        hdr = '0;
        nh  = (runt_at > 0) ? runt_at : HDR_BYTES;
        for (int i = 0; i < nh; i++) begin
            b    = 8'(seed + i);
            last = (runt_at > 0) && (i == nh - 1);
            src_q[p].push_back({last, b});
            hdr  = {hdr[HDR_BYTES*8-9:0], b};
        end
        if (runt_at > 0) begin
            e.kind = 2'd2; e.data = 128'h2; exp_q.push_back(e);
        end else begin
            for (int j = 0; j < plen; j++) begin
                b    = 8'(seed * 7 + j * 3 + 1);
                last = (j == plen - 1);
                src_q[p].push_back({last, b});
                if (j < LEN_MAX) begin
                    e.kind = 2'd0; e.data = 128'({last, b}); exp_q.push_back(e);
                end
            end
            if (plen > LEN_MAX) begin
                e.kind = 2'd2; e.data = 128'h3; exp_q.push_back(e);
            end else begin
                e.kind = 2'd1; e.data = 128'({hdr, LEN_W'(plen), PID_W'(p)});
                exp_q.push_back(e);
            end
        end
        update_inputs();
    endtask

    task automatic sb_compare(input logic [1:0] kind, input logic [127:0] data);
        ev_t e;
        ev_cnt++;
        if (exp_q.size() == 0) begin
            check("sb_unexpected_event", 128'(exp_q.size()), 128'(1));
        end else begin
            e = exp_q.pop_front();
            check("ev_kind", 128'(kind), 128'(e.kind));
            check("ev_data", data, e.data);
        end
    endtask

    // Stimulus changes happen just after the falling edge
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || src_busy()) && n < budget) begin
            step();
            n++;
        end
        check({tag, "_drained"}, 128'(exp_q.size()), 128'(0));
        repeat (3) step();
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        for (int p = 0; p < NPORT; p++) src_q[p].delete();
        exp_q.delete();
        stall = '0;
        update_inputs();
        step();
        check("rst_rden", 128'(bus.i_fifo_rden), 128'(0));
        step();
        arst_n = 1'b1;
    endtask

    // Output monitor: registered outputs sampled on the falling edge
    always @(negedge clk) begin
        if (arst_n) begin
            if (bus.b_fifo_wren) sb_compare(2'd0, 128'({bus.b_fifo_del, bus.b_fifo_din}));
            if (bus.h_fifo_wren) sb_compare(2'd1, 128'(bus.h_fifo_din));
            if (bus.drop_pulse || (bus.b_fifo_del && !bus.b_fifo_wren))
                sb_compare(2'd2, 128'({bus.drop_pulse, bus.b_fifo_del}));
        end
    end

    // Ingress FIFO model: capture pops just before the rising edge, retire them just after
    initial begin
        forever begin
            @(negedge clk);
            #3;
            pend_rden  = bus.i_fifo_rden;
            pend_empty = bus.i_fifo_empty;
            @(posedge clk);
            #1;
            for (int p = 0; p < NPORT; p++) begin
                if (pend_rden[p]) begin
                    pops++;
                    check("rden_on_empty", 128'(pend_empty[p]), 128'(0));
                    if (src_q[p].size() > 0) void'(src_q[p].pop_front());
                end
            end
            update_inputs();
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int ev0;
        bus.h_fifo_full  = 1'b0;
        bus.b_fifo_afull = 1'b0;
        update_inputs();

        // Reset values
        step();
        check("rst_rden", 128'(bus.i_fifo_rden), 128'(0));
        check("rst_h_wren", 128'(bus.h_fifo_wren), 128'(0));
        check("rst_b_wren", 128'(bus.b_fifo_wren), 128'(0));
        check("rst_b_del", 128'(bus.b_fifo_del), 128'(0));
        check("rst_drop", 128'(bus.drop_pulse), 128'(0));
        check("rst_h_din", 128'(bus.h_fifo_din), 128'(0));
        arst_n = 1'b1;
        step();

        // Single port 2 frame, 14 + 46 bytes
        pops = 0;
        push_frame(2, 8'h10, 46, 0);
        wait_drain("single", 400);
        check("single_pops", 128'(pops), 128'(60));

        // Round-robin over ports 0,1,3 from a fresh reset
        do_reset();
        for (int r = 0; r < 3; r++) begin
            push_frame(0, 8'h40 + r * 16, 3 + r, 0);
            push_frame(1, 8'h41 + r * 16, 4 + r, 0);
            push_frame(3, 8'h43 + r * 16, 5 + r, 0);
        end
        wait_drain("rr", 1000);

        // Runt: delimiter on header byte 6
        pops = 0;
        push_frame(1, 8'h80, 10, 6);
        wait_drain("runt", 100);
        check("runt_pops", 128'(pops), 128'(6));

        // Back-pressure from the header FIFO, then release
        pops = 0;
        bus.h_fifo_full = 1'b1;
        push_frame(0, 8'hA0, 8, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("hfull_hold_rden", 128'(bus.i_fifo_rden), 128'(0));
        end
        check("hfull_hold_pops", 128'(pops), 128'(0));
        bus.h_fifo_full = 1'b0;
        step();
        check("hfull_grant", 128'(bus.i_fifo_rden), 128'(4'b0001));
        wait_drain("hfull", 200);

        // Back-pressure from the body FIFO, then release
        pops = 0;
        bus.b_fifo_afull = 1'b1;
        push_frame(3, 8'hB0, 9, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bafull_hold_rden", 128'(bus.i_fifo_rden), 128'(0));
        end
        check("bafull_hold_pops", 128'(pops), 128'(0));
        bus.b_fifo_afull = 1'b0;
        step();
        check("bafull_grant", 128'(bus.i_fifo_rden), 128'(4'b1000));
        wait_drain("bafull", 200);

        // Empty toggled every other cycle while the frame streams
        pops = 0;
        push_frame(3, 8'hC0, 24, 0);
        for (int n = 0; n < 400 && (exp_q.size() != 0 || src_busy()); n++) begin
            step();
            stall[3] = ~stall[3];
            update_inputs();
        end
        stall = '0;
        update_inputs();
        wait_drain("toggle", 50);
        check("toggle_pops", 128'(pops), 128'(38));

        // Oversize payload saturates the length and is discarded
        pops = 0;
        push_frame(0, 8'hE0, 70, 0);
        wait_drain("oversize", 400);
        check("oversize_pops", 128'(pops), 128'(84));

        // Reset mid-frame: no further writes, next grant restarts at port 0
        push_frame(2, 8'h33, 30, 0);
        repeat (20) step();
        ev0 = ev_cnt;
        do_reset();
        repeat (10) step();
        check("midrst_no_writes", 128'(ev_cnt - ev0), 128'(0));
        push_frame(0, 8'h50, 5, 0);
        push_frame(1, 8'h60, 6, 0);
        wait_drain("post_rst", 300);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
